// File: rtl/vfx_ctrl_pkg.sv
// ============================================================================
// Module      : vfx_ctrl_pkg
// Description : Shared button indices and publish-FSM encoding for the
//               video effect controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vfx_ctrl_pkg;

  localparam int c_num_buttons = 4;

  localparam int c_btn_next   = 0;
  localparam int c_btn_prev   = 1;
  localparam int c_btn_home   = 2;
  localparam int c_btn_freeze = 3;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FRAME = 2'd1,
    ST_OFFER      = 2'd2
  } pub_state_e;

endpackage : vfx_ctrl_pkg

`default_nettype wire

// File: rtl/debounce.sv
// ============================================================================
// Module      : debounce
// Description : Two-flop synchroniser plus a stability counter; the output
//               level follows the input only after DEBOUNCE_COUNTS equal samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce #(
  parameter int DEBOUNCE_COUNTS = 2500
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level
);

  localparam int CNT_W = (DEBOUNCE_COUNTS > 1) ? $clog2(DEBOUNCE_COUNTS) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_COUNTS - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    r_sync1 <= i_raw;
    r_sync2 <= r_sync1;
  end

  // Reset adopts the synchronised input so a held button is not seen as a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == c_cnt_last) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_level = r_level;

endmodule : debounce

`default_nettype wire

// File: rtl/effect_mode_ctrl.sv
// ============================================================================
// Module      : effect_mode_ctrl
// Description : Button-driven effect mode selector that publishes its staged
//               configuration to the video pipeline once per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module effect_mode_ctrl
  import vfx_ctrl_pkg::*;
#(
  parameter int NUM_MODES         = 8,
  parameter int DEBOUNCE_COUNTS   = 2500,
  parameter int LONG_PRESS_COUNTS = 50_000_000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [3:0]                   buttons,
  input  logic                         frame_start,
  output logic [$clog2(NUM_MODES)-1:0] cfg_mode,
  output logic                         cfg_bypass,
  output logic                         cfg_valid,
  input  logic                         cfg_ready,
  output logic                         frozen
);

  localparam int MODE_W = $clog2(NUM_MODES);
  localparam int HOLD_W = $clog2(LONG_PRESS_COUNTS + 1);

  localparam logic [MODE_W-1:0] c_mode_max = MODE_W'(NUM_MODES - 1);
  localparam logic [HOLD_W-1:0] c_long     = HOLD_W'(LONG_PRESS_COUNTS);
  localparam logic [HOLD_W-1:0] c_long_m1  = HOLD_W'(LONG_PRESS_COUNTS - 1);

  logic [c_num_buttons-1:0] w_level;
  logic [c_num_buttons-1:0] r_level_q;
  logic [c_num_buttons-1:0] w_rise;
  logic [c_num_buttons-1:0] w_fall;
  logic [c_num_buttons-1:0] w_set;
  logic [c_num_buttons-1:0] w_serve;
  logic [c_num_buttons-1:0] r_pending;

  logic              r_hold_armed;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_long_evt;
  logic              w_short_evt;
  logic              r_b2_long;

  logic [MODE_W-1:0] r_stg_mode;
  logic              r_stg_bypass;
  logic              r_frozen;
  logic              r_dirty;
  logic              w_pub_load;
  pub_state_e        r_state;
  logic [MODE_W-1:0] r_cfg_mode;
  logic              r_cfg_bypass;

  genvar gi;
  generate
    for (gi = 0; gi < c_num_buttons; gi++) begin : g_debounce
      debounce #(
        .DEBOUNCE_COUNTS(DEBOUNCE_COUNTS)
      ) u_debounce (
        .clk    (clk),
        .rst    (reset),
        .i_raw  (buttons[gi]),
        .o_level(w_level[gi])
      );
    end
  endgenerate

  assign w_rise = w_level & ~r_level_q;
  assign w_fall = ~w_level & r_level_q;

  // Button 2 events come from the hold timer, not directly from its edge.
  assign w_long_evt  = r_hold_armed && w_level[c_btn_home] && (r_hold_cnt == c_long_m1);
  assign w_short_evt = r_hold_armed && w_fall[c_btn_home] && (r_hold_cnt != c_long);

  always_comb begin
    w_set               = w_rise;
    w_set[c_btn_home]   = w_long_evt | w_short_evt;
    w_serve             = '0;
    if (r_pending[c_btn_next])        w_serve[c_btn_next]   = 1'b1;
    else if (r_pending[c_btn_prev])   w_serve[c_btn_prev]   = 1'b1;
    else if (r_pending[c_btn_home])   w_serve[c_btn_home]   = 1'b1;
    else if (r_pending[c_btn_freeze]) w_serve[c_btn_freeze] = 1'b1;
  end

  assign w_pub_load = (r_state == ST_WAIT_FRAME) && frame_start && !r_frozen;

  always_ff @(posedge clk) begin
    r_level_q <= w_level;
    if (reset) begin
      r_pending    <= '0;
      r_hold_armed <= 1'b0;
      r_hold_cnt   <= '0;
      r_b2_long    <= 1'b0;
      r_stg_mode   <= '0;
      r_stg_bypass <= 1'b0;
      r_frozen     <= 1'b0;
      r_dirty      <= 1'b0;
      r_state      <= ST_IDLE;
      r_cfg_mode   <= '0;
      r_cfg_bypass <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_serve) | w_set;

      if (w_rise[c_btn_home]) begin
        r_hold_armed <= 1'b1;
        r_hold_cnt   <= '0;
      end else if (!w_level[c_btn_home]) begin
        r_hold_armed <= 1'b0;
        r_hold_cnt   <= '0;
      end else if (r_hold_armed && (r_hold_cnt != c_long)) begin
        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
      end

      if (w_long_evt || w_short_evt) r_b2_long <= w_long_evt;

      if (w_serve[c_btn_next]) begin
        r_stg_mode <= (r_stg_mode == c_mode_max) ? '0 : r_stg_mode + MODE_W'(1);
      end else if (w_serve[c_btn_prev]) begin
        r_stg_mode <= (r_stg_mode == '0) ? c_mode_max : r_stg_mode - MODE_W'(1);
      end else if (w_serve[c_btn_home]) begin
        if (r_b2_long) begin
          r_stg_mode   <= '0;
          r_stg_bypass <= 1'b0;
        end else begin
          r_stg_bypass <= ~r_stg_bypass;
        end
      end else if (w_serve[c_btn_freeze]) begin
        r_frozen <= ~r_frozen;
      end

      // A newly served event outranks the clear from publishing.
      if (|r_pending)      r_dirty <= 1'b1;
      else if (w_pub_load) r_dirty <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (r_dirty && !r_frozen) r_state <= ST_WAIT_FRAME;
        end
        ST_WAIT_FRAME: begin
          if (w_pub_load) begin
            r_state      <= ST_OFFER;
            r_cfg_mode   <= r_stg_mode;
            r_cfg_bypass <= r_stg_bypass;
          end
        end
        ST_OFFER: begin
          if (cfg_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cfg_mode   = r_cfg_mode;
  assign cfg_bypass = r_cfg_bypass;
  assign cfg_valid  = (r_state == ST_OFFER);
  assign frozen     = r_frozen;

endmodule : effect_mode_ctrl

`default_nettype wire

// File: tb/tb_effect_mode_ctrl.sv
// ============================================================================
// Module      : tb_effect_mode_ctrl
// Description : Directed self-checking bench for effect_mode_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_effect_mode_ctrl;
  import vfx_ctrl_pkg::*;

  localparam int NUM_MODES = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] buttons = 4'b0000;
  logic       frame_start = 1'b0;
  logic [2:0] cfg_mode;
  logic       cfg_bypass;
  logic       cfg_valid;
  logic       cfg_ready = 1'b0;
  logic       frozen;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  effect_mode_ctrl #(
    .NUM_MODES        (NUM_MODES),
    .DEBOUNCE_COUNTS  (4),
    .LONG_PRESS_COUNTS(20)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .buttons    (buttons),
    .frame_start(frame_start),
    .cfg_mode   (cfg_mode),
    .cfg_bypass (cfg_bypass),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .frozen     (frozen)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int idx, input int hold);
    buttons[idx] = 1'b1;
    tick(hold);
    buttons[idx] = 1'b0;
    tick(16);
  endtask

  task automatic frame_and_wait(output logic got);
    got = 1'b0;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (cfg_valid) begin
        got = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic accept();
    cfg_ready = 1'b1;
    tick(1);
    cfg_ready = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    logic got;
    reset = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(1);
    n_vec++; if (cfg_mode !== 3'd0) begin n_err++; $display("FAIL reset_mode: got %0d expected 0", cfg_mode); end
    n_vec++; if (cfg_bypass !== 1'b0) begin n_err++; $display("FAIL reset_bypass: got %b expected 0", cfg_bypass); end
    n_vec++; if (cfg_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", cfg_valid); end
    n_vec++; if (frozen !== 1'b0) begin n_err++; $display("FAIL reset_frozen: got %b expected 0", frozen); end
    frame_and_wait(got);
    n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL reset_no_offer: got valid %b expected 0", got); end
  endtask

  task automatic test_next_wrap();
    logic       got;
    logic [2:0] exp_mode;
    for (int k = 0; k < 9; k++) begin
      exp_mode = 3'((k + 1) % NUM_MODES);
      press(c_btn_next, 8);
      frame_and_wait(got);
      n_vec++;
      if (got !== 1'b1 || cfg_mode !== exp_mode || cfg_bypass !== 1'b0) begin
        n_err++;
        $display("FAIL next_wrap[%0d]: got valid=%b mode=%0d bypass=%b expected valid=1 mode=%0d bypass=0",
                 k, got, cfg_mode, cfg_bypass, exp_mode);
      end
      accept();
    end
    n_vec++; if (cfg_valid !== 1'b0) begin n_err++; $display("FAIL next_after_accept: got valid %b expected 0", cfg_valid); end
  endtask

  task automatic test_hold();
    logic got;
    press(c_btn_home, 10);
    frame_and_wait(got);
    n_vec++;
    if (got !== 1'b1 || cfg_mode !== 3'd1 || cfg_bypass !== 1'b1) begin
      n_err++;
      $display("FAIL hold_short: got valid=%b mode=%0d bypass=%b expected valid=1 mode=1 bypass=1", got, cfg_mode, cfg_bypass);
    end
    accept();
    press(c_btn_home, 30);
    frame_and_wait(got);
    n_vec++;
    if (got !== 1'b1 || cfg_mode !== 3'd0 || cfg_bypass !== 1'b0) begin
      n_err++;
      $display("FAIL hold_long: got valid=%b mode=%0d bypass=%b expected valid=1 mode=0 bypass=0", got, cfg_mode, cfg_bypass);
    end
    accept();
    frame_and_wait(got);
    n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL hold_release_event: got valid %b expected 0", got); end
    n_vec++; if (dut.r_dirty !== 1'b0) begin n_err++; $display("FAIL hold_release_dirty: got %b expected 0", dut.r_dirty); end
  endtask

  task automatic test_simultaneous();
    logic got;
    logic seen_up = 1'b0;
    logic seen_down = 1'b0;
    buttons[1:0] = 2'b11;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (i == 8) buttons[1:0] = 2'b00;
      if (dut.r_stg_mode == 3'd1) seen_up = 1'b1;
      if (dut.r_stg_mode == 3'd7) seen_down = 1'b1;
    end
    n_vec++;
    if (seen_up !== 1'b1 || seen_down !== 1'b0) begin
      n_err++;
      $display("FAIL simul_order: got seen1=%b seen7=%b expected seen1=1 seen7=0", seen_up, seen_down);
    end
    n_vec++; if (dut.r_stg_mode !== 3'd0) begin n_err++; $display("FAIL simul_net_mode: got %0d expected 0", dut.r_stg_mode); end
    n_vec++; if (dut.r_dirty !== 1'b1) begin n_err++; $display("FAIL simul_dirty: got %b expected 1", dut.r_dirty); end
    frame_and_wait(got);
    n_vec++;
    if (got !== 1'b1 || cfg_mode !== 3'd0 || cfg_bypass !== 1'b0) begin
      n_err++;
      $display("FAIL simul_offer: got valid=%b mode=%0d bypass=%b expected valid=1 mode=0 bypass=0", got, cfg_mode, cfg_bypass);
    end
    accept();
  endtask

  task automatic test_freeze();
    logic got;
    int   offers = 0;
    press(c_btn_freeze, 8);
    n_vec++; if (frozen !== 1'b1) begin n_err++; $display("FAIL freeze_on: got %b expected 1", frozen); end
    repeat (3) press(c_btn_next, 8);
    repeat (3) begin
      frame_and_wait(got);
      if (got === 1'b1) offers++;
    end
    n_vec++; if (offers != 0) begin n_err++; $display("FAIL freeze_offers: got %0d expected 0", offers); end
    n_vec++; if (dut.r_stg_mode !== 3'd3) begin n_err++; $display("FAIL freeze_staged: got %0d expected 3", dut.r_stg_mode); end
    press(c_btn_freeze, 8);
    n_vec++; if (frozen !== 1'b0) begin n_err++; $display("FAIL freeze_off: got %b expected 0", frozen); end
    frame_and_wait(got);
    n_vec++;
    if (got !== 1'b1 || cfg_mode !== 3'd3) begin
      n_err++;
      $display("FAIL freeze_release_offer: got valid=%b mode=%0d expected valid=1 mode=3", got, cfg_mode);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic got;
    int   bad = 0;
    press(c_btn_next, 8);
    frame_and_wait(got);
    n_vec++;
    if (got !== 1'b1 || cfg_mode !== 3'd4) begin
      n_err++;
      $display("FAIL bp_first: got valid=%b mode=%0d expected valid=1 mode=4", got, cfg_mode);
    end
    buttons[c_btn_next] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      if (i == 8) buttons[c_btn_next] = 1'b0;
      if (cfg_valid !== 1'b1 || cfg_mode !== 3'd4) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable cycles expected 0", bad); end
    n_vec++; if (dut.r_stg_mode !== 3'd5) begin n_err++; $display("FAIL bp_staged: got %0d expected 5", dut.r_stg_mode); end
    accept();
    frame_and_wait(got);
    n_vec++;
    if (got !== 1'b1 || cfg_mode !== 3'd5) begin
      n_err++;
      $display("FAIL bp_next_frame: got valid=%b mode=%0d expected valid=1 mode=5", got, cfg_mode);
    end
    accept();
  endtask

  task automatic test_reset_mid_offer();
    logic got;
    press(c_btn_next, 8);
    frame_and_wait(got);
    n_vec++;
    if (got !== 1'b1 || cfg_mode !== 3'd6) begin
      n_err++;
      $display("FAIL rst_pre_offer: got valid=%b mode=%0d expected valid=1 mode=6", got, cfg_mode);
    end
    buttons = 4'b0101;
    reset = 1'b1;
    tick(5);
    reset = 1'b0;
    tick(1);
    n_vec++;
    if (cfg_valid !== 1'b0 || cfg_mode !== 3'd0 || cfg_bypass !== 1'b0 || frozen !== 1'b0) begin
      n_err++;
      $display("FAIL rst_outputs: got valid=%b mode=%0d bypass=%b frozen=%b expected all 0",
               cfg_valid, cfg_mode, cfg_bypass, frozen);
    end
    tick(20);
    n_vec++; if (dut.r_dirty !== 1'b0) begin n_err++; $display("FAIL rst_held_dirty: got %b expected 0", dut.r_dirty); end
    buttons = 4'b0000;
    tick(20);
    frame_and_wait(got);
    n_vec++; if (got !== 1'b0) begin n_err++; $display("FAIL rst_no_offer: got valid %b expected 0", got); end
    press(c_btn_next, 8);
    frame_and_wait(got);
    n_vec++;
    if (got !== 1'b1 || cfg_mode !== 3'd1 || cfg_bypass !== 1'b0) begin
      n_err++;
      $display("FAIL rst_new_press: got valid=%b mode=%0d bypass=%b expected valid=1 mode=1 bypass=0", got, cfg_mode, cfg_bypass);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_next_wrap();
    test_hold();
    test_simultaneous();
    test_freeze();
    test_back_to_back();
    test_reset_mid_offer();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_effect_mode_ctrl

`default_nettype wire
